// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch stage, the MEM stage, the shared
// single-ported memory and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 10
) ();
    // Fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    // Data requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ready;
    // Memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    // Pipeline stalls
    logic          stall_if;
    logic          stall_mem;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    // Requester/memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data accesses win arbitration unless fetch has been passed over STARVE times
// in a row. Each access runs IDLE (grant) -> [BUSY for reads] -> DONE (ready).
module mem_port_arbiter #(
    parameter int unsigned AW     = 10,
    parameter int unsigned LAT    = 2,
    parameter int unsigned STARVE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,  // active-high despite the name
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [2:0] LatM1     = 3'(LAT - 1);
    localparam logic [2:0] StarveMax = 3'(STARVE);

    state_e        state_q, state_d;
    logic          owner_d_q, owner_d_d;  // 1 = data stage owns the access
    logic          we_q, we_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    streak_q, streak_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          d_ready_q, d_ready_d;

    logic          grant_d, grant_if;
    logic          mem_en_c, mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [31:0]   mem_wdata_c;

    // Grant decision; only acted upon in IDLE
    always_comb begin
        grant_d  = bus.d_req & (~bus.if_req | (streak_q < StarveMax));
        grant_if = ~grant_d & bus.if_req;
    end

    // Next-state and memory-port strobes
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_d || grant_if) begin
                    mem_en_c  = 1'b1;
                    owner_d_d = grant_d;
                    we_d      = grant_d & bus.d_we;
                    if (grant_d) begin
                        mem_addr_c  = bus.d_addr;
                        mem_we_c    = bus.d_we;
                        mem_wdata_c = bus.d_wdata;
                        // Count only grants that actually made fetch wait
                        if (bus.if_req) begin
                            streak_d = (streak_q == StarveMax) ? streak_q : streak_q + 3'd1;
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        mem_addr_c = bus.if_addr;
                        streak_d   = '0;
                    end
                    if (grant_d && bus.d_we) begin
                        state_d   = StDone;
                        d_ready_d = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = LatM1;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 3'd0) begin
                    if (owner_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            // No grant here so a requester still holding req cannot re-issue
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StIdle;
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            streak_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
        end
    end

    // Outputs; combinational paths are masked so everything reads 0 during reset
    always_comb begin
        bus.mem_en    = mem_en_c & ~rst_n;
        bus.mem_we    = mem_we_c & ~rst_n;
        bus.mem_addr  = rst_n ? '0 : mem_addr_c;
        bus.mem_wdata = rst_n ? '0 : mem_wdata_c;
        bus.if_rdata  = if_rdata_q;
        bus.if_ready  = if_ready_q;
        bus.d_rdata   = d_rdata_q;
        bus.d_ready   = d_ready_q;
        bus.stall_if  = bus.if_req & ~if_ready_q & ~rst_n;
        bus.stall_mem = bus.d_req & ~d_ready_q & ~rst_n;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (LAT=2 and LAT=1), cycle-exact checks
// of grants, ready pulses, read capture timing, starvation guard and reset.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.AW(10)) ifa ();
    mem_port_arbiter_if #(.AW(10)) ifb ();

    mem_port_arbiter #(.AW(10), .LAT(2), .STARVE(3)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mem_port_arbiter #(.AW(10), .LAT(1), .STARVE(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] t4_en, t4_we, t4_drdy, t4_irdy;
    logic [9:0]  t6_en, t6_rdy;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        ifa.if_req = 1'b0; ifa.if_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        ifa.d_addr = '0; ifa.d_wdata = '0; ifa.mem_rdata = '0;
        ifb.if_req = 1'b0; ifb.if_addr = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
        ifb.d_addr = '0; ifb.d_wdata = '0; ifb.mem_rdata = '0;

        // Held reset with requests asserted: every output stays 0
        step();
        ifa.if_req = 1'b1; ifa.d_req = 1'b1; ifb.if_req = 1'b1;
        step();
        @(negedge clk);
        check("rst_mem_en", ifa.mem_en, 0);
        check("rst_stall_if", ifa.stall_if, 0);
        check("rst_stall_mem", ifa.stall_mem, 0);
        check("rst_b_mem_en", ifb.mem_en, 0);
        check("rst_if_rdata", ifa.if_rdata, 0);
        step();
        ifa.if_req = 1'b0; ifa.d_req = 1'b0; ifb.if_req = 1'b0;
        rst_n = 1'b0;

        // Test 1: single fetch read, LAT=2; grant in the first cycle after release
        ifa.if_req = 1'b1; ifa.if_addr = 10'h010; ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t1_c0_en", ifa.mem_en, 1);
        check("t1_c0_addr", ifa.mem_addr, 32'h010);
        check("t1_c0_stall", ifa.stall_if, 1);
        step();
        @(negedge clk);
        check("t1_c1_en", ifa.mem_en, 0);
        check("t1_c1_addr", ifa.mem_addr, 0);
        check("t1_c1_stall", ifa.stall_if, 1);
        step();
        ifa.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_c2_ready", ifa.if_ready, 0);
        check("t1_c2_stall", ifa.stall_if, 1);
        step();
        ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t1_c3_ready", ifa.if_ready, 1);
        check("t1_c3_rdata", ifa.if_rdata, 32'hDEADBEEF);
        check("t1_c3_stall", ifa.stall_if, 0);
        check("t1_c3_en", ifa.mem_en, 0);
        step();
        ifa.if_req = 1'b0;
        @(negedge clk);
        check("t1_c4_ready", ifa.if_ready, 0);
        check("t1_c4_hold", ifa.if_rdata, 32'hDEADBEEF);
        step();

        // Test 2: simultaneous fetch and data read; data wins, fetch follows
        ifa.if_req = 1'b1; ifa.if_addr = 10'h044;
        ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 10'h020;
        @(negedge clk);
        check("t2_c0_en", ifa.mem_en, 1);
        check("t2_c0_addr", ifa.mem_addr, 32'h020);
        check("t2_c0_we", ifa.mem_we, 0);
        check("t2_c0_stall_mem", ifa.stall_mem, 1);
        check("t2_c0_stall_if", ifa.stall_if, 1);
        step();
        step();
        ifa.mem_rdata = 32'hD00D0001;
        @(negedge clk);
        check("t2_c2_dready", ifa.d_ready, 0);
        step();
        ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t2_c3_dready", ifa.d_ready, 1);
        check("t2_c3_drdata", ifa.d_rdata, 32'hD00D0001);
        check("t2_c3_en", ifa.mem_en, 0);
        check("t2_c3_stall_mem", ifa.stall_mem, 0);
        check("t2_c3_stall_if", ifa.stall_if, 1);
        step();
        ifa.d_req = 1'b0;
        @(negedge clk);
        check("t2_c4_en", ifa.mem_en, 1);
        check("t2_c4_addr", ifa.mem_addr, 32'h044);
        check("t2_c4_dready", ifa.d_ready, 0);
        step();
        step();
        ifa.mem_rdata = 32'h1F000002;
        step();
        ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t2_c7_iready", ifa.if_ready, 1);
        check("t2_c7_irdata", ifa.if_rdata, 32'h1F000002);
        step();
        ifa.if_req = 1'b0;

        // Test 3: data write; strobes only in the grant cycle, later changes ignored
        ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 10'h030; ifa.d_wdata = 32'h12345678;
        @(negedge clk);
        check("t3_c0_en", ifa.mem_en, 1);
        check("t3_c0_we", ifa.mem_we, 1);
        check("t3_c0_addr", ifa.mem_addr, 32'h030);
        check("t3_c0_wdata", ifa.mem_wdata, 32'h12345678);
        step();
        ifa.d_addr = 10'h3FF; ifa.d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("t3_c1_dready", ifa.d_ready, 1);
        check("t3_c1_en", ifa.mem_en, 0);
        check("t3_c1_we", ifa.mem_we, 0);
        check("t3_c1_wdata", ifa.mem_wdata, 0);
        step();
        ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        @(negedge clk);
        check("t3_c2_en", ifa.mem_en, 0);
        check("t3_c2_dready", ifa.d_ready, 0);
        step();

        // Test 4: starvation guard: D,D,D writes then forced IF read, then D again
        t4_en   = 12'b010001010101;
        t4_we   = 12'b010000010101;
        t4_drdy = 12'b100000101010;
        t4_irdy = 12'b001000000000;
        ifa.if_req = 1'b1; ifa.if_addr = 10'h0F0;
        ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 10'h040; ifa.d_wdata = 32'hA5A5A5A5;
        for (int c = 0; c < 12; c++) begin
            ifa.mem_rdata = 32'h5EED0000 + 32'(c);
            if (c == 11) begin
                ifa.d_req = 1'b0;
                ifa.if_req = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t4_c%0d_en", c), ifa.mem_en, 32'(t4_en[c]));
            check($sformatf("t4_c%0d_we", c), ifa.mem_we, 32'(t4_we[c]));
            check($sformatf("t4_c%0d_dready", c), ifa.d_ready, 32'(t4_drdy[c]));
            check($sformatf("t4_c%0d_iready", c), ifa.if_ready, 32'(t4_irdy[c]));
            if (c == 6) check("t4_c6_addr", ifa.mem_addr, 32'h0F0);
            if (c == 9) check("t4_c9_irdata", ifa.if_rdata, 32'h5EED0008);
            step();
        end

        // Test 5: reset in the middle of a read abandons it without a ready pulse
        ifa.if_req = 1'b1; ifa.if_addr = 10'h050; ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t5_c0_en", ifa.mem_en, 1);
        check("t5_c0_addr", ifa.mem_addr, 32'h050);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_c1_en", ifa.mem_en, 0);
        check("t5_c1_addr", ifa.mem_addr, 0);
        check("t5_c1_stall", ifa.stall_if, 0);
        check("t5_c1_iready", ifa.if_ready, 0);
        check("t5_c1_irdata", ifa.if_rdata, 0);
        check("t5_c1_drdata", ifa.d_rdata, 0);
        step();
        ifa.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("t5_c2_iready", ifa.if_ready, 0);
        step();
        rst_n = 1'b0;
        ifa.if_addr = 10'h060; ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t5_c3_en", ifa.mem_en, 1);
        check("t5_c3_addr", ifa.mem_addr, 32'h060);
        check("t5_c3_iready", ifa.if_ready, 0);
        step();
        @(negedge clk);
        check("t5_c4_iready", ifa.if_ready, 0);
        step();
        ifa.mem_rdata = 32'h600D600D;
        step();
        ifa.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("t5_c6_iready", ifa.if_ready, 1);
        check("t5_c6_irdata", ifa.if_rdata, 32'h600D600D);
        step();
        ifa.if_req = 1'b0;

        // Test 6: LAT=1 with fetch held high: one grant per ready, spacing 3
        t6_en  = 10'b0001001001;
        t6_rdy = 10'b0100100100;
        ifb.if_req = 1'b1; ifb.if_addr = 10'h077;
        for (int c = 0; c < 10; c++) begin
            ifb.mem_rdata = 32'hB0000000 + 32'(c);
            if (c == 9) ifb.if_req = 1'b0;
            @(negedge clk);
            check($sformatf("t6_c%0d_en", c), ifb.mem_en, 32'(t6_en[c]));
            check($sformatf("t6_c%0d_ready", c), ifb.if_ready, 32'(t6_rdy[c]));
            if (t6_en[c]) check($sformatf("t6_c%0d_addr", c), ifb.mem_addr, 32'h077);
            if (t6_rdy[c]) begin
                check($sformatf("t6_c%0d_rdata", c), ifb.if_rdata, 32'hB0000000 + 32'(c - 1));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported 32-bit memory between the fetch stage and the MEM stage of the 5-stage MIPS pipeline, so instructions and data can live in one unified memory. The block grants the port to one requester at a time and sequences each access through a fixed memory latency. It returns read data with a one-cycle ready pulse and drives stall signals into the hazard and stall logic. Data accesses have priority, and a starvation guard protects fetch.

Parameters:
AW, 10, word-address width.
LAT, 2, memory read latency in cycles (legal 1..7); read data is valid LAT cycles after the grant cycle.
STARVE, 3, consecutive data grants allowed while if_req is pending before fetch is forced (legal 1..7).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active-high (asserted at 1; the name keeps the codebase spelling).
if_req  in  1  fetch read request; held with if_addr until if_ready.
if_addr  in  AW  fetch word address.
if_rdata  out  32  fetch read data, valid while if_ready=1.
if_ready  out  1  one-cycle completion pulse for fetch.
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready.
d_we  in  1  1 = write, 0 = read.
d_addr  in  AW  data word address.
d_wdata  in  32  write data.
d_rdata  out  32  data read result, valid while d_ready=1.
d_ready  out  1  one-cycle completion pulse for data.
mem_en  out  1  memory access strobe, grant cycle only.
mem_we  out  1  memory write strobe, grant cycle only.
mem_addr  out  AW  memory address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data.
stall_if  out  1  fetch stalled: if_req & ~if_ready.
stall_mem  out  1  MEM stage stalled: d_req & ~d_ready.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registered state: owner (IF/D), op (rd/wr), 3-bit latency counter, streak counter (0..STARVE), if_rdata and d_rdata registers, and the ready flags.
- IDLE, grant decision (combinational):
  - If d_req and (~if_req or streak<STARVE), grant D.
  - Else if if_req, grant IF.
  - The grant cycle is G. In G: mem_en=1, mem_addr=granted address, mem_we=d_we (D only), mem_wdata=d_wdata (D only).
  - Outside G: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Streak counter:
  - Increments (saturating) on a D grant while if_req=1.
  - Clears on an IF grant, and on a D grant while if_req=0.
- Write: after G, go to DONE. d_ready=1 in cycle G+1. mem_we is high only in G.
- Read: after G, go to BUSY with counter=LAT-1.
  - In BUSY, decrement the counter each cycle.
  - In the cycle where the counter reads 0 (cycle G+LAT), capture mem_rdata into the owner's rdata register and go to DONE.
  - The ready pulse occurs in cycle G+LAT+1.
  - LAT=1: BUSY lasts one cycle (G+1) and captures mem_rdata there.
- DONE:
  - The owner's ready=1 for exactly one cycle.
  - No grant is made in DONE, so a still-high req cannot double-issue.
  - Next state is IDLE. Back-to-back issue spacing is therefore LAT+2 cycles for reads and 2 cycles for writes.
- rdata registers hold their last value until overwritten.
- Dropping req mid-transaction does not abort it: the access completes and ready still pulses.
- Address or data changes after G are ignored.
- stall_if and stall_mem are combinational from req and the registered ready.
- Reset (async, any state):
  - state=IDLE, counters=0, rdata registers=0, ready=0, so all outputs are 0 while reset is held.
  - An in-flight access is abandoned with no ready pulse.
  - The first grant can occur in the first cycle after release.

Test Plan:
- LAT=2, if_req at cycle 0 with if_addr=0x010, memory returns 0xDEADBEEF in cycle 2 -> mem_en=1 only in cycle 0 with mem_addr=0x010; if_ready=1 in cycle 3 with if_rdata=0xDEADBEEF; stall_if=1 in cycles 0-2.
- if_req and d_req (read, 0x020) both asserted at cycle 0, LAT=2 -> D granted cycle 0, d_ready cycle 3; IF granted cycle 4, if_ready cycle 7.
- Write with d_addr=0x030, d_wdata=0x12345678 -> mem_we=1 with those values only in cycle 0; d_ready cycle 1; no further mem_en until a new grant at cycle 2 or later.
- STARVE=3, d_req continuously re-asserted for new accesses, if_req held high -> grants D, D, D, then IF; streak clears and D is granted next.
- Reset asserted in cycle 1 of a LAT=2 read, released cycle 3 -> all outputs 0 from assertion; no ready pulse; a new if_req is granted in the first cycle after release and completes normally.
- LAT=1, if_req held high continuously -> grants at cycles 0, 3, 6; if_ready at cycles 2, 5, 8; only one grant per ready.
